// File: rtl/mul.sv
// Iterative 32x32 multiplier, radix-2 shift-add on operand magnitudes.
// One multiplier bit per cycle; sign applied to the 64-bit product at the output.
//
// state | meaning
// IDLE  | waiting for valid; result holds the last completed product
// RUN   | 32 shift-add steps in progress, mul_stall high
module mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        valid,
    input  logic        sign,
    output logic        mul_stall,
    output logic [63:0] result
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] a_save, b_save;
    logic        sign_save;
    logic [32:0] acc_hi;
    logic [31:0] mplr, mcand_abs;

    logic        accept, last_step;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum;
    logic [63:0] prod;
    logic        neg;

    always_comb begin
        accept    = 1'b0;
        last_step = 1'b0;
        state_nx  = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
                RUN: if (cnt == 6'd32) begin
                    last_step = 1'b1;
                    state_nx  = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= 6'd0;
        else if (flush)          cnt <= 6'd0;
        else if (accept)         cnt <= 6'd1;
        else if (state == RUN)   cnt <= last_step ? 6'd0 : cnt + 6'd1;
    end

    // Magnitudes only for signed requests with a negative operand
    always_comb begin
        a_mag = (sign && a[31]) ? (~a + 32'd1) : a;
        b_mag = (sign && b[31]) ? (~b + 32'd1) : b;
    end

    // acc_hi[32] is always zero, so adding the full register equals adding its low 32 bits
    assign sum = acc_hi + {1'b0, (mplr[0] ? mcand_abs : 32'd0)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_save    <= 32'd0;
            b_save    <= 32'd0;
            sign_save <= 1'b0;
            acc_hi    <= 33'd0;
            mplr      <= 32'd0;
            mcand_abs <= 32'd0;
        end else if (accept) begin
            a_save    <= a;
            b_save    <= b;
            sign_save <= sign;
            acc_hi    <= 33'd0;
            mplr      <= b_mag;
            mcand_abs <= a_mag;
        end else if (state == RUN && !flush) begin
            {acc_hi, mplr} <= {1'b0, sum, mplr[31:1]};
        end
    end

    assign prod      = {acc_hi[31:0], mplr};
    assign neg       = sign_save & (a_save[31] ^ b_save[31]);
    assign result    = neg ? (~prod + 64'd1) : prod;
    assign mul_stall = |cnt;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: vector table through a result scoreboard,
// plus hand-written flush, async reset and back-to-back sequences.
module tb_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mul_stall;
    logic [63:0] result;

    always #5 clk = ~clk;

    mul dut (
        .clk(clk), .rst(rst), .flush(flush), .a(a), .b(b),
        .valid(valid), .sign(sign), .mul_stall(mul_stall), .result(result)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] sb[$];
    vec_t        vecs[16];

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'd0, x};
        ey = s ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_stall_end(output int n);
        n = 0;
        while (mul_stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [63:0] exp);
        a = x; b = y; sign = s; valid = 1'b1;
        sb.push_back(exp);
    endtask

    task automatic compare_pop(input string name);
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got %h", name, result);
        end else begin
            check(name, result, sb.pop_front());
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [63:0] exp);
        int n;
        drive(x, y, s, exp);
        @(negedge clk);
        valid = 1'b0;
        wait_stall_end(n);
        check({name, "_stall"}, 64'(n), 64'd32);
        compare_pop(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[1] = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};
        vecs[5] = '{32'hFFFFFFF9, 32'h00000003, 1'b0, 64'h00000002_FFFFFFEB};
        vecs[6] = '{32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, 64'h00000000_0000001E};
        vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF_00000001};
        for (int i = 8; i < 16; i++) begin
            vecs[i].a   = $urandom;
            vecs[i].b   = (i == 8) ? 32'd0 : $urandom;
            vecs[i].sgn = 1'(i % 2);
            vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].sgn);
        end

        repeat (3) @(negedge clk);
        check("reset_stall", 64'(mul_stall), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

        // Flush at cnt == 10, then flush together with valid in idle must not accept
        a = 32'h1234; b = 32'h10; sign = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        check("flush_pre_stall", 64'(mul_stall), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_drop", 64'(mul_stall), 64'd0);
        a = 32'd6; b = 32'd7; valid = 1'b1;
        @(negedge clk);
        check("flush_valid_no_accept", 64'(mul_stall), 64'd0);
        flush = 1'b0;
        run_op("flush_then_6x7", 32'd6, 32'd7, 1'b0, 64'h2A);

        // Asynchronous reset mid-run, observed without a clock edge
        a = 32'd9; b = 32'd9; sign = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_stall", 64'(mul_stall), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_stall", 64'(mul_stall), 64'd0);
        check("async_rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back: valid held high, second accept on the completion cycle
        drive(32'd5, 32'd5, 1'b1, 64'd25);
        @(negedge clk);
        wait_stall_end(n);
        check("b2b_first_stall", 64'(n), 64'd32);
        compare_pop("b2b_first");
        drive(32'hFFFFFFFE, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFC);
        @(negedge clk);
        check("b2b_no_gap", 64'(mul_stall), 64'd1);
        valid = 1'b0;
        wait_stall_end(n);
        check("b2b_second_stall", 64'(n), 64'd32);
        compare_pop("b2b_second");

        // Result must hold while idle with valid low
        repeat (3) @(negedge clk);
        check("hold_result", result, 64'hFFFFFFFF_FFFFFFFC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul.md
# mul

Iterative 32x32 multiplier for the execute stage: the forward-direction companion to the sequential divider. It sits beside the divider and shares the same request and stall contract, so the pipeline controls both units the same way. It executes MULT/MULTU one multiplier bit per cycle (radix-2 shift-add on magnitudes, sign fixed at the output) and returns a 64-bit {hi, lo} product, holding the pipeline stalled while busy.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous abort of any operation in progress.
- a  input  32  multiplicand.
- b  input  32  multiplier.
- valid  input  1  request; sampled only while idle.
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU).
- mul_stall  output  1  high while an operation is in progress.
- result  output  64  product; [63:32] = hi, [31:0] = lo.

## Operation
- State: `cnt[5:0]`, busy flag, `a_save`/`b_save`/`sign_save`, 33-bit `acc_hi`, 32-bit `mplr`, 32-bit `mcand_abs`.
- **Reset** (rst = 0, asynchronous): every register goes to 0. Outputs: mul_stall = 0, result = 64'h0.
- **IDLE** (busy = 0):
  - If valid = 1 and flush = 0: capture a, b and sign. Load `mcand_abs` = |a| and `mplr` = |b|. A magnitude is taken only when sign = 1 and the MSB = 1; otherwise the operand is used as-is.
  - On the same accept, clear `acc_hi`, set `cnt` = 1 and set busy = 1.
- **RUN** (busy = 1), one step per cycle:
  - sum[32:0] = {1'b0, acc_hi[31:0]} + (mplr[0] ? mcand_abs : 0).
  - {acc_hi, mplr} <= {1'b0, sum, mplr[31:1]} (right shift by 1; the carry enters bit 31 of hi).
  - cnt increments each step. On the step where cnt == 32, cnt <= 0 and busy <= 0.
- After 32 steps, {acc_hi[31:0], mplr} holds |a|·|b| exactly.
  - The maximum magnitude is 2^62 signed (0x80000000², fits) and (2^32−1)² unsigned.
- result (combinational from registers):
  - result = neg ? −P : P, where P = {acc_hi[31:0], mplr}.
  - neg = sign_save & (a_save[31] ^ b_save[31]).
  - Negation is 64-bit two's complement.
- **flush** = 1 (synchronous, highest priority after reset):
  - cnt <= 0, busy <= 0, no accept in that cycle.
  - The datapath registers may keep partial values; result is undefined until the next completed operation.
- mul_stall = |cnt.

## Timing
- Accept edge: the edge where IDLE, valid = 1 and flush = 0.
- mul_stall rises in the cycle after the accept edge and stays high for exactly 32 cycles.
- result is valid in the first cycle mul_stall is low after completion.
- result holds until the next accept edge, even if valid is low.
- The pipeline must keep a, b, sign and valid stable while mul_stall = 1; changes during RUN are ignored.
- Back-to-back operations:
  - If valid = 1 in the completion-visible cycle, that edge accepts a new operation.
  - The consumer must latch result combinationally in that same cycle.
- Flush edge:
  - A flush mid-run drops mul_stall in the next cycle.
  - Flush and valid in the same idle cycle: no accept.
- Reset mid-run: immediate return to IDLE with outputs 0. No clock is needed to observe this.

## Test plan
- **Unsigned maximum:** sign = 0, a = b = 0xFFFFFFFF, valid pulse.
  - mul_stall is high for exactly 32 cycles.
  - Then result = 0xFFFFFFFE_00000001.
- **Signed mixed signs:**
  - a = 0xFFFFFFF9 (−7), b = 3 → result = 0xFFFFFFFF_FFFFFFEB.
  - a = 0xFFFFFFFF, b = 1 → result = 0xFFFFFFFF_FFFFFFFF.
- **Signed corner:** a = b = 0x80000000 → result = 0x40000000_00000000.
  - Same operands with sign = 0 → result = 0x40000000_00000000 (unsigned 2^31·2^31 = 2^62, same bits).
- **Flush:** start 0x1234·0x10, then assert flush when cnt = 10.
  - mul_stall is 0 on the next cycle.
  - A new request 6·7 then yields result = 0x0000000000000002A after 32 stall cycles.
- **Reset and back-to-back:**
  - Drive rst low mid-run → mul_stall = 0 and result = 0 asynchronously.
  - After release, hold valid high across two requests (5·5 then 0xFFFFFFFE·2 signed).
  - The second accept lands on the completion cycle; results are 25 and then 0xFFFFFFFF_FFFFFFFC, with no idle gap.
